// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: hazard/stall controller driving enables and flushes of the 5-stage pipeline registers.
// Latency: zero; controls are combinational from state and inputs and take effect at the next clk edge.
// Backpressure: a pending data-memory access (mem_req && !mem_ready) freezes PC..EX/MEM and bubbles MEM/WB.
//
// Ports:
//   clk, rst (async, active-low)
//   id_rs/id_rt/id_uses_rs/id_uses_rt/id_jump           - ID-stage instruction info
//   ex_MemRead/ex_RegWriteAddr/ex_branch_taken           - EX-stage instruction info
//   mem_req/mem_ready/exc_req                            - MEM-stage access handshake and exception
//   pc_en, *_en, *_flush, pc_sel_exc                     - per-stage register controls
//   mem_timeout                                          - pulse when a memory wait is aborted
//   stall_cycles                                         - saturating count of cycles with pc_en=0
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16  // legal range 2..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_jump,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_RegWriteAddr,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        exc_req,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        pc_sel_exc,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;

  logic load_use;
  logic mem_stall;
  logic wait_expired;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_MemRead && (ex_RegWriteAddr != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_RegWriteAddr)) ||
                     (id_uses_rt && (id_rt == ex_RegWriteAddr)));

  assign mem_stall    = mem_req && !mem_ready;
  assign wait_expired = (wait_cnt == WAIT_LIMIT);

  // State register, wait counter and stall performance counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      wait_cnt     <= 8'd0;
      stall_cycles <= 32'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (!pc_en && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end

  // Next-state logic. The RUN cycle that detects the miss already counts as
  // wait cycle 0, so MEM_WAIT is entered with wait_cnt=1.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        // An exception outranks the memory wait; it flushes the access instead.
        if (!exc_req && mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready || wait_expired) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Output logic. Everything is gated off while reset is held.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    pc_sel_exc   = 1'b0;
    mem_timeout  = 1'b0;

    if (!rst) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (exc_req) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            pc_sel_exc   = 1'b1;
          end else if (mem_stall) begin
            // Freeze everything upstream of MEM; WB gets a bubble each cycle.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
          end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            // Hold the consumer in ID one cycle; the load moves on to MEM.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (id_jump) begin
            if_id_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          // Other events are held by the frozen stages and seen after release.
          if (mem_ready) begin
            pc_en = 1'b1;
          end else if (wait_expired) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            pc_sel_exc   = 1'b1;
            mem_timeout  = 1'b1;
          end else begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
          end
        end
        default: begin
          pc_en = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose: directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
// Latency: controls checked 1ns after inputs change on the falling edge.
// Backpressure: memory-wait freeze, release and timeout sequences are exercised directly.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_jump;
  logic        ex_MemRead;
  logic [4:0]  ex_RegWriteAddr;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        exc_req;
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        mem_wb_flush;
  logic        pc_sel_exc;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  // Control vector: {pc,if_id,id_ex,ex_mem,mem_wb}_en, {if_id,id_ex,ex_mem,mem_wb}_flush, pc_sel_exc, mem_timeout
  logic [10:0] ctl;
  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                pc_sel_exc, mem_timeout};

  localparam logic [10:0] C_RST = 11'b00000_0000_0_0;
  localparam logic [10:0] C_DEF = 11'b11111_0000_0_0;
  localparam logic [10:0] C_EXC = 11'b11111_1110_1_0;
  localparam logic [10:0] C_FRZ = 11'b00001_0001_0_0;
  localparam logic [10:0] C_BR  = 11'b11111_1100_0_0;
  localparam logic [10:0] C_LU  = 11'b00111_0100_0_0;
  localparam logic [10:0] C_JMP = 11'b11111_1000_0_0;
  localparam logic [10:0] C_TMO = 11'b11111_1110_1_1;

  int          n_chk;
  int          n_pass;
  logic [31:0] exp_stall;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_jump         (id_jump),
    .ex_MemRead      (ex_MemRead),
    .ex_RegWriteAddr (ex_RegWriteAddr),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .exc_req         (exc_req),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .mem_wb_flush    (mem_wb_flush),
    .pc_sel_exc      (pc_sel_exc),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    id_rs           = 5'd0;
    id_rt           = 5'd0;
    id_uses_rs      = 1'b0;
    id_uses_rt      = 1'b0;
    id_jump         = 1'b0;
    ex_MemRead      = 1'b0;
    ex_RegWriteAddr = 5'd0;
    ex_branch_taken = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b0;
    exc_req         = 1'b0;
  endtask

  // Sets up a load in EX writing 'dst' and an ID instruction reading rs/rt.
  task automatic set_lu(input logic [4:0] dst, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt);
    ex_MemRead      = 1'b1;
    ex_RegWriteAddr = dst;
    id_rs           = rs;
    id_uses_rs      = urs;
    id_rt           = rt;
    id_uses_rt      = urt;
  endtask

  task automatic step_check(input string tag, input logic [10:0] exp);
    @(negedge clk);
    #1;
    check(tag, 32'(ctl), 32'(exp));
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    exp_stall = 32'd0;
    idle();
    rst = 1'b0;
    #1;
    check("reset_ctl", 32'(ctl), 32'(C_RST));
    check("reset_stall", stall_cycles, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("run_idle", 32'(ctl), 32'(C_DEF));

    // Load-use on rs: one stall cycle.
    @(negedge clk);
    set_lu(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    #1;
    check("lu_rs", 32'(ctl), 32'(C_LU));
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    idle();
    #1;
    check("lu_clear", 32'(ctl), 32'(C_DEF));
    check("lu_stall_cnt", stall_cycles, exp_stall);

    // Load to r0 never stalls.
    @(negedge clk);
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    check("lu_r0", 32'(ctl), 32'(C_DEF));

    // Load-use on rt; then same register but rt not read.
    @(negedge clk);
    set_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
    #1;
    check("lu_rt", 32'(ctl), 32'(C_LU));
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    set_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b0);
    #1;
    check("lu_rt_unused", 32'(ctl), 32'(C_DEF));
    check("lu_r0_stall_cnt", stall_cycles, exp_stall);

    // Branch beats load-use: flush only.
    @(negedge clk);
    set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    check("br_lu", 32'(ctl), 32'(C_BR));
    @(negedge clk);
    idle();
    #1;
    check("br_stall_cnt", stall_cycles, exp_stall);

    // Jump alone, then jump behind a load-use (load-use wins).
    @(negedge clk);
    id_jump = 1'b1;
    #1;
    check("jump", 32'(ctl), 32'(C_JMP));
    @(negedge clk);
    set_lu(5'd12, 5'd12, 1'b1, 5'd0, 1'b0);
    #1;
    check("jump_lu", 32'(ctl), 32'(C_LU));
    exp_stall = exp_stall + 32'd1;

    // Exception beats load-use: flush, no stall.
    @(negedge clk);
    id_jump = 1'b0;
    exc_req = 1'b1;
    #1;
    check("exc_lu", 32'(ctl), 32'(C_EXC));
    @(negedge clk);
    idle();
    #1;
    check("exc_stall_cnt", stall_cycles, exp_stall);

    // Ready together with request: no stall.
    @(negedge clk);
    mem_req   = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("mem_hit", 32'(ctl), 32'(C_DEF));

    // Three-cycle memory wait with a branch pending: freeze, release, then branch.
    @(negedge clk);
    mem_ready       = 1'b0;
    ex_branch_taken = 1'b1;
    #1;
    check("mw_frz0", 32'(ctl), 32'(C_FRZ));
    step_check("mw_frz1", C_FRZ);
    step_check("mw_frz2", C_FRZ);
    exp_stall = exp_stall + 32'd3;
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("mw_release", 32'(ctl), 32'(C_DEF));
    check("mw_stall_cnt", stall_cycles, exp_stall);
    @(negedge clk);
    mem_req   = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("mw_branch_after", 32'(ctl), 32'(C_BR));

    // Timeout with MEM_TIMEOUT=4: four freeze cycles, then the abort cycle.
    @(negedge clk);
    idle();
    mem_req = 1'b1;
    #1;
    check("to_frz0", 32'(ctl), 32'(C_FRZ));
    for (int i = 1; i < 4; i++) step_check($sformatf("to_frz%0d", i), C_FRZ);
    step_check("to_abort", C_TMO);
    exp_stall = exp_stall + 32'd4;
    @(negedge clk);
    mem_req = 1'b0;
    #1;
    check("to_back_run", 32'(ctl), 32'(C_DEF));
    check("to_stall_cnt", stall_cycles, exp_stall);

    // Exception during a wait is held until release, then taken.
    @(negedge clk);
    mem_req = 1'b1;
    #1;
    check("we_frz0", 32'(ctl), 32'(C_FRZ));
    @(negedge clk);
    exc_req = 1'b1;
    #1;
    check("we_exc_ignored", 32'(ctl), 32'(C_FRZ));
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("we_release", 32'(ctl), 32'(C_DEF));
    @(negedge clk);
    mem_req   = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("we_exc_taken", 32'(ctl), 32'(C_EXC));
    exp_stall = exp_stall + 32'd2;
    @(negedge clk);
    idle();
    #1;
    check("we_stall_cnt", stall_cycles, exp_stall);

    // Async reset in the middle of a wait.
    @(negedge clk);
    mem_req = 1'b1;
    #1;
    check("ar_frz", 32'(ctl), 32'(C_FRZ));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("ar_ctl", 32'(ctl), 32'(C_RST));
    check("ar_stall", stall_cycles, 32'd0);
    #1;
    rst = 1'b1;
    idle();
    @(negedge clk);
    #1;
    check("ar_run", 32'(ctl), 32'(C_DEF));
    check("ar_stall_after", stall_cycles, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
